wb_ram_slave: RTL

//  Wishbone responder (slave) word-addressed RAM at the far end of the bus driven by fetch/cache/load units.

---
 rtl/wb_slave_pkg.sv | 9 +
 rtl/wb_bus_t.sv | 15 +
 rtl/sp_ram_be.sv | 26 ++
 rtl/wb_ram_slave.sv | 93 +++++++++
 4 files changed

// File: rtl/wb_slave_pkg.sv
// wb_slave_pkg: shared types, widths and address-range helper for the Wishbone RAM slave
package wb_slave_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_slv_state_t;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;
   function automatic logic in_range(input logic [31:0] adr, input logic [31:0] base, input logic [31:0] n_words);
      return adr >= base && ((adr - base) >> 2) < n_words;
   endfunction
endpackage

// File: rtl/wb_bus_t.sv
// wb_bus_t: Wishbone classic bus bundle with master and slave views
interface wb_bus_t;
   import wb_slave_pkg::*;
   logic                 wb_cyc;
   logic                 wb_stb;
   logic                 wb_we;
   logic [WB_SEL_W-1:0]  wb_sel;
   logic [31:0]          wb_adr;
   logic [WB_DATA_W-1:0] wb_dat_ms;
   logic [WB_DATA_W-1:0] wb_dat_sm;
   logic                 wb_ack;
   logic                 wb_err;
   modport master(output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms, input wb_dat_sm, wb_ack, wb_err);
   modport slave(input wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms, output wb_dat_sm, wb_ack, wb_err);
endinterface

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port word RAM with byte write enables and a registered read port
module sp_ram_be
   import wb_slave_pkg::*;
#(
   parameter int N_WORDS = 1024,
   parameter int AW      = $clog2(N_WORDS)
) (
   input  logic                 clk,
   input  logic                 rstn_i,
   input  logic                 en,
   input  logic                 we,
   input  logic [WB_SEL_W-1:0]  sel,
   input  logic [AW-1:0]        idx,
   input  logic [WB_DATA_W-1:0] wdat,
   output logic [WB_DATA_W-1:0] rdat
);
   logic [WB_DATA_W-1:0] mem [N_WORDS];
   // contents survive reset; only the read register is cleared
   always_ff @(posedge clk)
      if (en && we)
         for (int i = 0; i < WB_SEL_W; i++)
            if (sel[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) rdat <= '0;
      else if (en && !we) rdat <= mem[idx];
endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone word RAM responder with fixed wait states and byte-enabled writes.
// Define WB_SLAVE_ERR_EN to answer out-of-range or empty-sel writes with wb_err instead of wrapping.
module wb_ram_slave
   import wb_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          N_WORDS     = 1024,
   parameter int          WAIT_STATES = 0
) (
   input  logic     clk,
   input  logic     rstn_i,
   wb_bus_t.slave   wb_bus,
   output logic     busy_o
);
   localparam int AW = $clog2(N_WORDS);
   wb_slv_state_t        state;
   logic [3:0]           cnt;
   logic                 run;
   logic                 lat_we;
   logic [WB_SEL_W-1:0]  lat_sel;
   logic [31:0]          lat_adr;
   logic [WB_DATA_W-1:0] lat_dat;
   logic                 idle, req, fire, ok, ack_q;
   logic                 op_we;
   logic [WB_SEL_W-1:0]  op_sel;
   logic [31:0]          op_adr;
   logic [WB_DATA_W-1:0] op_dat;
   logic [AW-1:0]        idx;
   // with no wait states the request is served straight off the bus on its capture edge
   always_comb begin
      idle   = state == IDLE;
      req    = run && wb_bus.wb_cyc && wb_bus.wb_stb;
      op_we  = idle ? wb_bus.wb_we : lat_we;
      op_sel = idle ? wb_bus.wb_sel : lat_sel;
      op_adr = idle ? wb_bus.wb_adr : lat_adr;
      op_dat = idle ? wb_bus.wb_dat_ms : lat_dat;
      fire   = idle ? req && WAIT_STATES == 0 : state == WAIT && wb_bus.wb_cyc && cnt == '0;
      idx    = AW'((op_adr - BASE_ADDR) >> 2);
   end
`ifdef WB_SLAVE_ERR_EN
   logic err_q;
   assign ok = in_range(op_adr, BASE_ADDR, 32'(N_WORDS)) && !(op_we && op_sel == '0);
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) err_q <= 1'b0;
      else err_q <= fire && !ok;
   assign wb_bus.wb_err = err_q;
`else
   assign ok = 1'b1;
   assign wb_bus.wb_err = 1'b0;
`endif
   // run keeps a request held through reset release from being taken mid-reset
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) begin
         state   <= IDLE;
         cnt     <= '0;
         run     <= 1'b0;
         ack_q   <= 1'b0;
         lat_we  <= 1'b0;
         lat_sel <= '0;
         lat_adr <= '0;
         lat_dat <= '0;
      end else begin
         run   <= 1'b1;
         ack_q <= fire && ok;
         case (state)
            IDLE: if (req) begin
               lat_we  <= wb_bus.wb_we;
               lat_sel <= wb_bus.wb_sel;
               lat_adr <= wb_bus.wb_adr;
               lat_dat <= wb_bus.wb_dat_ms;
               state   <= WAIT_STATES > 0 ? WAIT : RESP;
               cnt     <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : '0;
            end
            WAIT:
               if (!wb_bus.wb_cyc) state <= IDLE;
               else if (cnt == '0) state <= RESP;
               else cnt <= cnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
   sp_ram_be #(.N_WORDS(N_WORDS), .AW(AW)) u_ram (
      .clk   (clk),
      .rstn_i(rstn_i),
      .en    (fire && ok),
      .we    (op_we),
      .sel   (op_sel),
      .idx   (idx),
      .wdat  (op_dat),
      .rdat  (wb_bus.wb_dat_sm)
   );
   assign wb_bus.wb_ack = ack_q;
   assign busy_o = state != IDLE;
endmodule
